// File: rtl/drr_in_arb_sched_pkg.sv
// Shared types, constants and helpers for the deficit-round-robin input-arbiter scheduler.
package drr_in_arb_sched_pkg;

    typedef enum logic [1:0] {
        ST_SCAN  = 2'd0,
        ST_CHECK = 2'd1,
        ST_XFER  = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        DEF_NOP = 2'd0,
        DEF_ADD = 2'd1,
        DEF_SUB = 2'd2,
        DEF_CLR = 2'd3
    } def_op_e;

    localparam logic [7:0]  DEFAULT_HDR_CTRL = 8'hFF;
    localparam int unsigned LEN_LSB          = 0;
    localparam int unsigned LEN_W            = 16;

    function automatic int unsigned log2_f(input int unsigned n);
        int unsigned r;
        r = 32'd0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                r = i + 32'd1;
            end
        end
        return r;
    endfunction

    // Adds a quantum to a deficit and clamps at the all-ones value of the given width.
    function automatic logic [31:0] def_sat_add(input logic [31:0] a, input logic [15:0] b,
                                                input int unsigned width);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, a} + {17'd0, b};
        lim = (33'd1 << width) - 33'd1;
        if (sum > lim) begin
            return lim[31:0];
        end else begin
            return sum[31:0];
        end
    endfunction

endpackage

// File: rtl/drr_in_arb_sched_if.sv
// Input FIFO heads and the outgoing user datapath bus of the input-arbiter scheduler.
interface drr_in_arb_sched_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int NUM_QUEUES = 8
) ();
    logic [NUM_QUEUES-1:0]            in_fifo_empty;
    logic [NUM_QUEUES*DATA_WIDTH-1:0] in_fifo_data;
    logic [NUM_QUEUES*CTRL_WIDTH-1:0] in_fifo_ctrl;
    logic [NUM_QUEUES-1:0]            in_fifo_rd_en;
    logic [DATA_WIDTH-1:0]            out_data;
    logic [CTRL_WIDTH-1:0]            out_ctrl;
    logic                             out_wr;
    logic                             out_rdy;

    modport master (
        input  in_fifo_empty, in_fifo_data, in_fifo_ctrl, out_rdy,
        output in_fifo_rd_en, out_data, out_ctrl, out_wr
    );

    modport slave (
        output in_fifo_empty, in_fifo_data, in_fifo_ctrl, out_rdy,
        input  in_fifo_rd_en, out_data, out_ctrl, out_wr
    );
endinterface

// File: rtl/drr_in_arb_sched_deficit_bank.sv
// Per-queue deficit counters; one add/subtract/clear on the selected queue per cycle.
module drr_deficit_bank
    import drr_in_arb_sched_pkg::*;
#(
    parameter int unsigned NUM_QUEUES = 8,
    parameter int unsigned DEF_WIDTH  = 17,
    localparam int unsigned QW        = log2_f(NUM_QUEUES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  def_op_e              op,
    input  logic [QW-1:0]        idx,
    input  logic [15:0]          operand,
    output logic [DEF_WIDTH-1:0] deficit_sel
);
    logic [DEF_WIDTH-1:0] def_r [NUM_QUEUES];

    assign deficit_sel = def_r[idx];

    // Deficit register update for the queue under the scheduler pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_QUEUES); i++) begin
                def_r[i] <= {DEF_WIDTH{1'b0}};
            end
        end else begin
            case (op)
                DEF_ADD: def_r[idx] <= DEF_WIDTH'(def_sat_add(32'(def_r[idx]), operand, DEF_WIDTH));
                DEF_SUB: def_r[idx] <= def_r[idx] - DEF_WIDTH'(operand);
                DEF_CLR: def_r[idx] <= {DEF_WIDTH{1'b0}};
                default: def_r[idx] <= def_r[idx];
            endcase
        end
    end
endmodule

// File: rtl/drr_in_arb_sched.sv
// Deficit-round-robin packet scheduler draining FWFT input FIFOs onto one datapath bus.
// Define IN_ARB_Q0_PRIO_EN to give queue 0 strict, uncharged priority at packet boundaries.
module drr_in_arb_sched
    import drr_in_arb_sched_pkg::*;
#(
    parameter int DATA_WIDTH                 = 64,
    parameter int CTRL_WIDTH                 = DATA_WIDTH / 8,
    parameter int NUM_QUEUES                 = 8,
    parameter int DEF_WIDTH                  = 17,
    parameter logic [CTRL_WIDTH-1:0] HDR_CTRL = CTRL_WIDTH'(DEFAULT_HDR_CTRL),
    localparam int QW                        = log2_f(NUM_QUEUES)
) (
    input  logic                 clk,
    input  logic                 reset,
    drr_in_arb_sched_if.master   bus,
    input  logic [15:0]          quantum,
    output logic                 state,
    output logic                 eop,
    output logic [QW-1:0]        cur_queue
);
    localparam logic [CTRL_WIDTH-1:0] CTRL_ZERO = {CTRL_WIDTH{1'b0}};

    arb_state_e state_r, state_s;
    logic [QW-1:0] ptr_r, ptr_s, saved_ptr_r, saved_ptr_s;
    logic seen_body_r, seen_body_s, done_r, done_s;
    logic prio_r, prio_s, resume_check_r, resume_check_s;
    logic out_wr_r, eop_r;
    logic [DATA_WIDTH-1:0] out_data_r;
    logic [CTRL_WIDTH-1:0] out_ctrl_r;

    logic [DATA_WIDTH-1:0] head_data_a [NUM_QUEUES];
    logic [CTRL_WIDTH-1:0] head_ctrl_a [NUM_QUEUES];
    logic [DATA_WIDTH-1:0] head_data_s;
    logic [CTRL_WIDTH-1:0] head_ctrl_s;
    logic head_empty_s, pop_s, end_s, len_fit_s, prio_take_s;
    logic [15:0] len_s, qeff_s, def_operand_s;
    logic [DEF_WIDTH-1:0] deficit_s;
    def_op_e def_op_s;

    for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_unpack
        assign head_data_a[g] = bus.in_fifo_data[g*DATA_WIDTH +: DATA_WIDTH];
        assign head_ctrl_a[g] = bus.in_fifo_ctrl[g*CTRL_WIDTH +: CTRL_WIDTH];
    end

    assign head_data_s  = head_data_a[ptr_r];
    assign head_ctrl_s  = head_ctrl_a[ptr_r];
    assign head_empty_s = bus.in_fifo_empty[ptr_r];
    assign len_s        = (head_ctrl_s == HDR_CTRL) ? head_data_s[LEN_LSB +: LEN_W] : 16'd0;
    assign qeff_s       = (quantum == 16'd0) ? 16'd1 : quantum;
    assign len_fit_s    = (DEF_WIDTH'(len_s) <= deficit_s);

    // done_r closes the pop window once the end word has left, for the decision cycle.
    assign pop_s = (state_r == ST_XFER) && !done_r && !head_empty_s && bus.out_rdy;
    assign end_s = pop_s && (head_ctrl_s != CTRL_ZERO) && seen_body_r;

`ifdef IN_ARB_Q0_PRIO_EN
    assign prio_take_s = !bus.in_fifo_empty[0];
`else
    assign prio_take_s = 1'b0;
`endif

    assign bus.in_fifo_rd_en = pop_s ? ({{(NUM_QUEUES-1){1'b0}}, 1'b1} << ptr_r)
                                     : {NUM_QUEUES{1'b0}};
    assign bus.out_data = out_data_r;
    assign bus.out_ctrl = out_ctrl_r;
    assign bus.out_wr   = out_wr_r;
    assign eop          = eop_r;
    assign state        = (state_r == ST_XFER);
    assign cur_queue    = ptr_r;

    drr_deficit_bank #(
        .NUM_QUEUES (NUM_QUEUES),
        .DEF_WIDTH  (DEF_WIDTH)
    ) u_bank (
        .clk         (clk),
        .reset       (reset),
        .op          (def_op_s),
        .idx         (ptr_r),
        .operand     (def_operand_s),
        .deficit_sel (deficit_s)
    );

    // Next-state, pointer and deficit-operation decode.
    always_comb begin
        state_s        = state_r;
        ptr_s          = ptr_r;
        seen_body_s    = seen_body_r;
        done_s         = done_r;
        prio_s         = prio_r;
        saved_ptr_s    = saved_ptr_r;
        resume_check_s = resume_check_r;
        def_op_s       = DEF_NOP;
        def_operand_s  = 16'd0;
        case (state_r)
            ST_SCAN: begin
                if (prio_take_s) begin
                    prio_s         = 1'b1;
                    saved_ptr_s    = ptr_r;
                    resume_check_s = 1'b0;
                    ptr_s          = {QW{1'b0}};
                    seen_body_s    = 1'b0;
                    done_s         = 1'b0;
                    state_s        = ST_XFER;
                end else if (head_empty_s) begin
                    def_op_s = DEF_CLR;
                    ptr_s    = ptr_r + QW'(1'b1);
                end else begin
                    def_op_s      = DEF_ADD;
                    def_operand_s = qeff_s;
                    state_s       = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (len_fit_s) begin
                    def_op_s      = DEF_SUB;
                    def_operand_s = len_s;
                    seen_body_s   = 1'b0;
                    done_s        = 1'b0;
                    state_s       = ST_XFER;
                end else begin
                    ptr_s   = ptr_r + QW'(1'b1);
                    state_s = ST_SCAN;
                end
            end
            ST_XFER: begin
                if (done_r) begin
                    done_s      = 1'b0;
                    seen_body_s = 1'b0;
                    if (prio_r) begin
                        if (prio_take_s) begin
                            state_s = ST_XFER;
                        end else begin
                            prio_s  = 1'b0;
                            ptr_s   = saved_ptr_r;
                            state_s = resume_check_r ? ST_CHECK : ST_SCAN;
                        end
                    end else if (head_empty_s) begin
                        def_op_s = DEF_CLR;
                        if (prio_take_s) begin
                            prio_s         = 1'b1;
                            saved_ptr_s    = ptr_r + QW'(1'b1);
                            resume_check_s = 1'b0;
                            ptr_s          = {QW{1'b0}};
                            state_s        = ST_XFER;
                        end else begin
                            ptr_s   = ptr_r + QW'(1'b1);
                            state_s = ST_SCAN;
                        end
                    end else if (prio_take_s) begin
                        prio_s         = 1'b1;
                        saved_ptr_s    = ptr_r;
                        resume_check_s = 1'b1;
                        ptr_s          = {QW{1'b0}};
                        state_s        = ST_XFER;
                    end else begin
                        state_s = ST_CHECK;
                    end
                end else if (pop_s) begin
                    if (end_s) begin
                        done_s = 1'b1;
                    end else if (head_ctrl_s == CTRL_ZERO) begin
                        seen_body_s = 1'b1;
                    end else begin
                        seen_body_s = seen_body_r;
                    end
                end else begin
                    done_s = done_r;
                end
            end
            default: state_s = ST_SCAN;
        endcase
    end

    // Scheduler state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_SCAN;
            ptr_r          <= {QW{1'b0}};
            saved_ptr_r    <= {QW{1'b0}};
            seen_body_r    <= 1'b0;
            done_r         <= 1'b0;
            prio_r         <= 1'b0;
            resume_check_r <= 1'b0;
        end else begin
            state_r        <= state_s;
            ptr_r          <= ptr_s;
            saved_ptr_r    <= saved_ptr_s;
            seen_body_r    <= seen_body_s;
            done_r         <= done_s;
            prio_r         <= prio_s;
            resume_check_r <= resume_check_s;
        end
    end

    // Datapath output register: a popped word appears exactly one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_wr_r   <= 1'b0;
            eop_r      <= 1'b0;
            out_data_r <= {DATA_WIDTH{1'b0}};
            out_ctrl_r <= CTRL_ZERO;
        end else begin
            out_wr_r <= pop_s;
            eop_r    <= end_s;
            if (pop_s) begin
                out_data_r <= head_data_s;
                out_ctrl_r <= head_ctrl_s;
            end
        end
    end
endmodule
